pcs_descrambler: RTL and testbench

- Receive-path 64b/66b self-synchronizing descrambler, polynomial G(x) = 1 + x^39 + x^58.
- Sits between the RX gearbox/block-sync stage and the 64b/66b decoder. 32-bit datapath; each 66-bit block arrives as two 32-bit words, with the 2-bit sync header attached to the first word.
- Strips the scrambling from the payload and forwards the header unscrambled.
- Reports descrambler lock and counts invalid sync headers.

---
 rtl/pcs_descrambler.sv | 89 ++++++++
 tb/tb_pcs_descrambler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pcs_descrambler.sv
// Receive-side 64b/66b self-synchronizing descrambler, G(x) = 1 + x^39 + x^58.
// Tracks fill of the 58-bit state for lock reporting and counts invalid sync headers.
module pcs_descrambler #(
   parameter int DATA_WIDTH         = 32,
   parameter bit DESCRAMBLER_BYPASS = 1'b0,
   parameter int ERR_CNT_WIDTH      = 8
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_block_lock,
   input  logic                     i_data_valid,
   input  logic [DATA_WIDTH-1:0]    i_data,
   input  logic                     i_hdr_valid,
   input  logic [1:0]               i_hdr,
   output logic                     o_data_valid,
   output logic [DATA_WIDTH-1:0]    o_data,
   output logic                     o_hdr_valid,
   output logic [1:0]               o_hdr,
   output logic                     o_locked,
   output logic [ERR_CNT_WIDTH-1:0] o_hdr_err_cnt
);

   typedef enum logic {FILL, LOCKED} state_t;

   state_t                state, state_next;
   logic                  fill_cnt, fill_cnt_next;
   logic [57:0]           lfsr, lfsr_next;
   logic [DATA_WIDTH-1:0] descr;
   logic                  hdr_bad;

   // Unrolled serial descrambler: the received (scrambled) bit feeds the state.
   always_comb begin : descramble
      logic [57:0] s;
      s     = lfsr;
      descr = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         descr[i] = i_data[i] ^ s[38] ^ s[57];
         s        = {s[56:0], i_data[i]};
      end
      lfsr_next = s;
   end

   // Two valid words (64 bits) fully seed the 58-bit state; loss of block lock restarts the fill.
   always_comb begin
      state_next    = state;
      fill_cnt_next = fill_cnt;
      if (!i_block_lock) begin
         state_next    = FILL;
         fill_cnt_next = 1'b0;
      end else if (i_data_valid && state == FILL) begin
         if (fill_cnt) begin
            state_next    = LOCKED;
            fill_cnt_next = 1'b0;
         end else begin
            fill_cnt_next = 1'b1;
         end
      end
   end

   assign hdr_bad  = i_data_valid && i_hdr_valid && i_block_lock &&
                     (i_hdr == 2'b00 || i_hdr == 2'b11);
   assign o_locked = (state == LOCKED);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= FILL;
         fill_cnt      <= 1'b0;
         lfsr          <= '0;
         o_data_valid  <= 1'b0;
         o_data        <= '0;
         o_hdr_valid   <= 1'b0;
         o_hdr         <= 2'b00;
         o_hdr_err_cnt <= '0;
      end else begin
         state        <= state_next;
         fill_cnt     <= fill_cnt_next;
         o_data_valid <= i_data_valid;
         o_hdr_valid  <= i_hdr_valid && i_data_valid;
         o_hdr        <= i_hdr;
         if (i_data_valid) begin
            lfsr   <= lfsr_next;
            o_data <= DESCRAMBLER_BYPASS ? i_data : descr;
         end
         if (hdr_bad && o_hdr_err_cnt != {ERR_CNT_WIDTH{1'b1}})
            o_hdr_err_cnt <= o_hdr_err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pcs_descrambler.sv
// Randomized bench for pcs_descrambler: a normal and a bypass instance share stimulus
// and are compared every cycle against a bit-history reference model.
module tb_pcs_descrambler;

   logic        clk = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_block_lock = 1'b0;
   logic        i_data_valid = 1'b0;
   logic [31:0] i_data = '0;
   logic        i_hdr_valid = 1'b0;
   logic [1:0]  i_hdr = '0;

   logic        o_data_valid, o_hdr_valid, o_locked;
   logic [31:0] o_data;
   logic [1:0]  o_hdr;
   logic [7:0]  o_hdr_err_cnt;

   logic        b_data_valid, b_hdr_valid, b_locked;
   logic [31:0] b_data;
   logic [1:0]  b_hdr;
   logic [7:0]  b_hdr_err_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   bit          rx_hist[$];
   bit          scr_hist[$];
   logic [31:0] m_data, m_bdata;
   logic        m_valid, m_hdr_valid, m_locked;
   logic [1:0]  m_hdr;
   int          m_fill, m_err;

   logic [31:0] plain[10];
   logic [31:0] run_a[10];
   logic [31:0] cipher;

   always #5 clk = ~clk;

   pcs_descrambler #(.DATA_WIDTH(32), .DESCRAMBLER_BYPASS(1'b0), .ERR_CNT_WIDTH(8)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_block_lock(i_block_lock),
      .i_data_valid(i_data_valid), .i_data(i_data), .i_hdr_valid(i_hdr_valid), .i_hdr(i_hdr),
      .o_data_valid(o_data_valid), .o_data(o_data), .o_hdr_valid(o_hdr_valid), .o_hdr(o_hdr),
      .o_locked(o_locked), .o_hdr_err_cnt(o_hdr_err_cnt)
   );

   pcs_descrambler #(.DATA_WIDTH(32), .DESCRAMBLER_BYPASS(1'b1), .ERR_CNT_WIDTH(8)) dut_bypass (
      .i_clk(clk), .i_reset(i_reset), .i_block_lock(i_block_lock),
      .i_data_valid(i_data_valid), .i_data(i_data), .i_hdr_valid(i_hdr_valid), .i_hdr(i_hdr),
      .o_data_valid(b_data_valid), .o_data(b_data), .o_hdr_valid(b_hdr_valid), .o_hdr(b_hdr),
      .o_locked(b_locked), .o_hdr_err_cnt(b_hdr_err_cnt)
   );

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: out bit = in bit ^ received bit 39 back ^ received bit 58 back (zeros after reset).
   task automatic model_step(input logic rst, input logic lock, input logic valid,
                             input logic [31:0] data, input logic hvalid, input logic [1:0] hdr);
      int n;
      bit t1, t2;
      if (rst) begin
         rx_hist.delete();
         m_data = '0; m_bdata = '0; m_valid = 0; m_hdr_valid = 0; m_hdr = '0;
         m_locked = 0; m_fill = 0; m_err = 0;
         return;
      end
      m_valid     = valid;
      m_hdr_valid = valid && hvalid;
      m_hdr       = hdr;
      if (valid) begin
         for (int i = 0; i < 32; i++) begin
            n  = rx_hist.size();
            t1 = (n >= 39) ? rx_hist[n-39] : 1'b0;
            t2 = (n >= 58) ? rx_hist[n-58] : 1'b0;
            m_data[i] = data[i] ^ t1 ^ t2;
            rx_hist.push_back(data[i]);
            if (rx_hist.size() > 58) void'(rx_hist.pop_front());
         end
         m_bdata = data;
      end
      if (!lock) begin
         m_fill = 0; m_locked = 0;
      end else if (valid && !m_locked) begin
         m_fill++;
         if (m_fill == 2) begin m_locked = 1; m_fill = 0; end
      end
      if (valid && hvalid && lock && (hdr == 2'b00 || hdr == 2'b11) && m_err < 255) m_err++;
   endtask

   task automatic apply_stimulus(input logic rst, input logic lock, input logic valid,
                                 input logic [31:0] data, input logic hvalid, input logic [1:0] hdr);
      i_reset = rst; i_block_lock = lock; i_data_valid = valid;
      i_data = data; i_hdr_valid = hvalid; i_hdr = hdr;
      @(posedge clk);
      #1;
      model_step(rst, lock, valid, data, hvalid, hdr);
      check_output("data_valid", 64'(o_data_valid), 64'(m_valid));
      check_output("data", 64'(o_data), 64'(m_data));
      check_output("hdr_valid", 64'(o_hdr_valid), 64'(m_hdr_valid));
      check_output("hdr", 64'(o_hdr), 64'(m_hdr));
      check_output("locked", 64'(o_locked), 64'(m_locked));
      check_output("err_cnt", 64'(o_hdr_err_cnt), 64'(m_err));
      check_output("byp_data", 64'(b_data), 64'(m_bdata));
      check_output("byp_locked", 64'(b_locked), 64'(m_locked));
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++)
         apply_stimulus(1'b0, 1'b1, 1'b0, $urandom, 1'($urandom), 2'($urandom));
   endtask

   // Transmit-side scrambler seeded with all ones: c = p ^ c(-39) ^ c(-58).
   task automatic scramble(input logic [31:0] p, output logic [31:0] c);
      int n;
      for (int i = 0; i < 32; i++) begin
         n = scr_hist.size();
         c[i] = p[i] ^ scr_hist[n-39] ^ scr_hist[n-58];
         scr_hist.push_back(c[i]);
         void'(scr_hist.pop_front());
      end
   endtask

   task automatic self_sync_run(input bit gaps, input bit compare_prev);
      apply_stimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, 2'b00);
      scr_hist.delete();
      for (int i = 0; i < 58; i++) scr_hist.push_back(1'b1);
      for (int w = 0; w < 10; w++) begin
         if (gaps) idle_cycles($urandom_range(0, 3));
         scramble(plain[w], cipher);
         apply_stimulus(1'b0, 1'b1, 1'b1, cipher, (w % 2 == 0), 2'b01);
         check_output("sync_locked", 64'(o_locked), 64'(w >= 1));
         if (w >= 2) check_output("sync_plain", 64'(o_data), 64'(plain[w]));
         if (compare_prev) check_output("gap_same", 64'(o_data), 64'(run_a[w]));
         else run_a[w] = o_data;
      end
   endtask

   initial begin
      // Reset with random inputs, then an all-zero first word.
      for (int k = 0; k < 3; k++)
         apply_stimulus(1'b1, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 2'($urandom));
      check_output("rst_data", 64'(o_data), 64'd0);
      check_output("rst_err", 64'(o_hdr_err_cnt), 64'd0);
      apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 2'b00);
      check_output("first_zero", 64'(o_data), 64'd0);
      check_output("first_unlocked", 64'(o_locked), 64'd0);

      // Self-sync, then the same plaintext with random idle gaps.
      for (int w = 0; w < 10; w++) plain[w] = $urandom;
      self_sync_run(1'b0, 1'b0);
      self_sync_run(1'b1, 1'b1);

      // Headers: two valid, two invalid, then saturation.
      apply_stimulus(1'b0, 1'b1, 1'b1, $urandom, 1'b1, 2'b01);
      check_output("hdr01", 64'(o_hdr), 64'd1);
      apply_stimulus(1'b0, 1'b1, 1'b1, $urandom, 1'b1, 2'b10);
      check_output("hdr10", 64'(o_hdr), 64'd2);
      apply_stimulus(1'b0, 1'b1, 1'b1, $urandom, 1'b1, 2'b00);
      check_output("hdr00", 64'(o_hdr), 64'd0);
      apply_stimulus(1'b0, 1'b1, 1'b1, $urandom, 1'b1, 2'b11);
      check_output("hdr11", 64'(o_hdr), 64'd3);
      check_output("err_two", 64'(o_hdr_err_cnt), 64'd2);
      for (int k = 0; k < 300; k++) begin
         apply_stimulus(1'b0, 1'b1, 1'b1, $urandom, 1'b1, 2'b00);
         apply_stimulus(1'b0, 1'b1, 1'b1, $urandom, 1'b0, 2'($urandom));
      end
      check_output("err_sat", 64'(o_hdr_err_cnt), 64'd255);
      idle_cycles(2);
      check_output("err_hold", 64'(o_hdr_err_cnt), 64'd255);

      // Lock loss for one cycle, then refill over two words.
      apply_stimulus(1'b0, 1'b0, 1'b0, $urandom, 1'b0, 2'b01);
      check_output("lockloss", 64'(o_locked), 64'd0);
      apply_stimulus(1'b0, 1'b1, 1'b1, $urandom, 1'b1, 2'b01);
      check_output("refill1", 64'(o_locked), 64'd0);
      apply_stimulus(1'b0, 1'b1, 1'b1, $urandom, 1'b0, 2'b01);
      check_output("refill2", 64'(o_locked), 64'd1);

      // Bypass instance passes the payload unchanged.
      apply_stimulus(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'b01);
      check_output("bypass", 64'(b_data), 64'hDEAD_BEEF);

      // Fully random traffic, including lock drops with simultaneous valid words.
      for (int k = 0; k < 400; k++)
         apply_stimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                        1'($urandom), $urandom, 1'($urandom), 2'($urandom));

      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
